// File: rtl/wav_pkg.sv
// Shared types and constants for the WAV header parser.
// FOURCC values are the four file bytes assembled little-endian.
package wav_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RIFF_ID,
    S_RIFF_SIZE,
    S_WAVE_ID,
    S_CHUNK_ID,
    S_CHUNK_SIZE,
    S_FMT_BODY,
    S_SKIP,
    S_DONE,
    S_ERROR
  } wav_state_e;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_RIFF     = 3'd1;
  localparam logic [2:0] ERR_WAVE     = 3'd2;
  localparam logic [2:0] ERR_NOT_PCM  = 3'd3;
  localparam logic [2:0] ERR_NO_FMT   = 3'd4;
  localparam logic [2:0] ERR_LIMIT    = 3'd5;
  localparam logic [2:0] ERR_FMT_SIZE = 3'd6;

  localparam logic [31:0] FOURCC_RIFF = 32'h4646_4952;
  localparam logic [31:0] FOURCC_WAVE = 32'h4556_4157;
  localparam logic [31:0] FOURCC_FMT  = 32'h2074_6d66;
  localparam logic [31:0] FOURCC_DATA = 32'h6174_6164;

  // States whose bytes are gathered into 32-bit words by the accumulator.
  function automatic logic is_word_state(input wav_state_e s);
    return s inside {S_RIFF_ID, S_RIFF_SIZE, S_WAVE_ID, S_CHUNK_ID, S_CHUNK_SIZE};
  endfunction

endpackage

// File: rtl/wav_le_accum.sv
// 32-bit little-endian byte accumulator used for chunk ids and sizes.
// o_word is the completed word in the same cycle as the 4th byte (o_full).
module wav_le_accum (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_full
);

  logic [23:0] r_word;
  logic [1:0]  r_cnt;

  assign o_word = {i_byte, r_word};
  assign o_full = i_valid && (r_cnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_valid) begin
      r_word <= o_word[31:8];
      r_cnt  <= r_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/wav_header_parser.sv
// Streams a WAV file header byte by byte and extracts the PCM fmt fields
// plus the location and size of the 'data' chunk.
//
// state      | meaning
// IDLE       | waiting for start_i
// RIFF_ID    | expecting "RIFF"
// RIFF_SIZE  | discarding the RIFF size
// WAVE_ID    | expecting "WAVE"
// CHUNK_ID   | reading a chunk id
// CHUNK_SIZE | reading a chunk size, then dispatching on the id
// FMT_BODY   | capturing fmt fields and skipping the remainder (+pad)
// SKIP       | discarding an unknown chunk body (+pad)
// DONE       | 'data' found, outputs valid
// ERROR      | parse failed, error_o holds the code
module wav_header_parser
  import wav_pkg::*;
#(
  parameter int MAX_HDR_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [2:0]  error_o,
  output logic [31:0] sampling_rate_o,
  output logic [7:0]  audio_channels_o,
  output logic [15:0] bits_per_sample_o,
  output logic [31:0] data_offset_o,
  output logic [31:0] data_size_o
);

  wav_state_e  r_state, w_state_next;
  logic [2:0]  w_err_next;
  logic        w_busy, w_accept;
  logic [31:0] w_word;
  logic        w_full;
  logic [31:0] w_pos_next;

  logic [31:0] r_pos;
  logic [31:0] r_chunk_id;
  logic [32:0] r_remain;
  logic [4:0]  r_fmt_idx;
  logic [7:0]  r_fmt_lo;
  logic        r_fmt_seen;
  logic [2:0]  r_err;
  logic [31:0] r_rate;
  logic [7:0]  r_channels;
  logic [15:0] r_bits;
  logic [31:0] r_data_offset;
  logic [31:0] r_data_size;

  assign w_accept   = byte_valid_i && !start_i && w_busy;
  assign w_pos_next = r_pos + 32'd1;

  wav_le_accum u_accum (
    .clk     (clk),
    .rst     (rst),
    .i_clear (start_i),
    .i_valid (w_accept && is_word_state(r_state)),
    .i_byte  (byte_i),
    .o_word  (w_word),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_state <= S_IDLE;
    else if (start_i) r_state <= S_RIFF_ID;
    else              r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_err_next   = ERR_NONE;
    if (w_accept) begin
      case (r_state)
        S_RIFF_ID: if (w_full) begin
          if (w_word == FOURCC_RIFF) w_state_next = S_RIFF_SIZE;
          else begin w_state_next = S_ERROR; w_err_next = ERR_RIFF; end
        end
        S_RIFF_SIZE: if (w_full) w_state_next = S_WAVE_ID;
        S_WAVE_ID: if (w_full) begin
          if (w_word == FOURCC_WAVE) w_state_next = S_CHUNK_ID;
          else begin w_state_next = S_ERROR; w_err_next = ERR_WAVE; end
        end
        S_CHUNK_ID: if (w_full) w_state_next = S_CHUNK_SIZE;
        S_CHUNK_SIZE: if (w_full) begin
          if (r_chunk_id == FOURCC_FMT) begin
            if (w_word < 32'd16) begin w_state_next = S_ERROR; w_err_next = ERR_FMT_SIZE; end
            else w_state_next = S_FMT_BODY;
          end else if (r_chunk_id == FOURCC_DATA) begin
            if (!r_fmt_seen) begin w_state_next = S_ERROR; w_err_next = ERR_NO_FMT; end
            else w_state_next = S_DONE;
          end else if (w_word == 32'd0) w_state_next = S_CHUNK_ID;
          else w_state_next = S_SKIP;
        end
        S_FMT_BODY: begin
          if (r_fmt_idx == 5'd1 && {byte_i, r_fmt_lo} != 16'd1) begin
            w_state_next = S_ERROR;
            w_err_next   = ERR_NOT_PCM;
          end else if (r_remain == 33'd1) w_state_next = S_CHUNK_ID;
        end
        S_SKIP: if (r_remain == 33'd1) w_state_next = S_CHUNK_ID;
        default: ;
      endcase
      // Content errors on this byte win over the position limit.
      if (w_state_next != S_DONE && w_state_next != S_ERROR &&
          w_pos_next == 32'(MAX_HDR_BYTES)) begin
        w_state_next = S_ERROR;
        w_err_next   = ERR_LIMIT;
      end
    end
  end

  always_comb begin
    w_busy = !(r_state inside {S_IDLE, S_DONE, S_ERROR});
    busy_o = w_busy;
    done_o = (r_state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || start_i) begin
      r_pos         <= '0;
      r_chunk_id    <= '0;
      r_remain      <= '0;
      r_fmt_idx     <= '0;
      r_fmt_lo      <= '0;
      r_fmt_seen    <= 1'b0;
      r_err         <= ERR_NONE;
      r_rate        <= '0;
      r_channels    <= '0;
      r_bits        <= '0;
      r_data_offset <= '0;
      r_data_size   <= '0;
    end else if (w_accept) begin
      r_pos <= w_pos_next;
      if (w_err_next != ERR_NONE) r_err <= w_err_next;
      case (r_state)
        S_CHUNK_ID: if (w_full) r_chunk_id <= w_word;
        S_CHUNK_SIZE: if (w_full) begin
          // Odd-sized chunks carry one pad byte.
          r_remain  <= {1'b0, w_word} + {32'd0, w_word[0]};
          r_fmt_idx <= '0;
          if (r_chunk_id == FOURCC_FMT) r_fmt_seen <= 1'b1;
          if (r_chunk_id == FOURCC_DATA && r_fmt_seen) begin
            r_data_size   <= w_word;
            r_data_offset <= w_pos_next;
          end
        end
        S_FMT_BODY: begin
          r_remain <= r_remain - 33'd1;
          if (r_fmt_idx != 5'd16) r_fmt_idx <= r_fmt_idx + 5'd1;
          case (r_fmt_idx)
            5'd0:  r_fmt_lo        <= byte_i;
            5'd2:  r_channels      <= byte_i;
            5'd4:  r_rate[7:0]     <= byte_i;
            5'd5:  r_rate[15:8]    <= byte_i;
            5'd6:  r_rate[23:16]   <= byte_i;
            5'd7:  r_rate[31:24]   <= byte_i;
            5'd14: r_bits[7:0]     <= byte_i;
            5'd15: r_bits[15:8]    <= byte_i;
            default: ;
          endcase
        end
        S_SKIP: r_remain <= r_remain - 33'd1;
        default: ;
      endcase
    end
  end

  assign error_o           = r_err;
  assign sampling_rate_o   = r_rate;
  assign audio_channels_o  = r_channels;
  assign bits_per_sample_o = r_bits;
  assign data_offset_o     = r_data_offset;
  assign data_size_o       = r_data_size;

endmodule
